// File: rtl/operand_sel_mux.sv
// Registered N:1 operand-select mux with valid/ready handshake and a 2-entry skid buffer.
// Optional macro OPERAND_SEL_RANGE_CHK_EN adds a sticky sel_err output for out-of-range selects.
module operand_sel_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_cnt
`ifdef OPERAND_SEL_RANGE_CHK_EN
    ,
    output logic                    sel_err
`endif
);

    // State bits double as {skid_valid, out_valid}, so both are straight register outputs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t             state;
    logic               skid_valid;
    logic [WIDTH-1:0]   skid_data;
    logic [SEL_W-1:0]   skid_sel;
    logic [WIDTH-1:0]   capt_data;
    logic               accept;
    logic               xfer;

    assign out_valid  = state[0];
    assign skid_valid = state[1];
    assign in_ready   = ~skid_valid;
    assign accept     = in_valid & in_ready;
    assign xfer       = out_valid & out_ready;

    // Select values with no matching input fall through to all-zero data.
    always_comb begin
        capt_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                capt_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_sel   <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data <= capt_data;
                        out_sel  <= sel;
                        state    <= HALF;
                    end
                end
                HALF: begin
                    if (accept && xfer) begin
                        out_data <= capt_data;
                        out_sel  <= sel;
                    end else if (accept) begin
                        skid_data <= capt_data;
                        skid_sel  <= sel;
                        state     <= FULL;
                    end else if (xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        out_data <= skid_data;
                        out_sel  <= skid_sel;
                        state    <= HALF;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

`ifdef OPERAND_SEL_RANGE_CHK_EN
    logic sel_in_range;

    always_comb begin
        sel_in_range = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_in_range = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_in_range) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_sel_mux.sv
// Scoreboard bench for operand_sel_mux: driver pushes expected words, a negedge monitor pops and compares.
// A second NUM_IN=3 instance exercises out-of-range selects (and sel_err when OPERAND_SEL_RANGE_CHK_EN is set).
module tb_operand_sel_mux;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  sel;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_bus;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_cnt;

    logic [47:0] in_bus3;
    logic [1:0]  sel3;
    logic        in_valid3;
    logic        in_ready3;
    logic [15:0] out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;
    logic [15:0] xfer_cnt3;
`ifdef OPERAND_SEL_RANGE_CHK_EN
    logic        sel_err;
    logic        sel_err3;
`endif

    exp_t        exp_q[$];
    int          check_cnt;
    int          pass_cnt;
    int          stall_cycles;
    logic [15:0] stream_exp[4];

    operand_sel_mux #(.WIDTH(16), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt)
`ifdef OPERAND_SEL_RANGE_CHK_EN
        , .sel_err(sel_err)
`endif
    );

    operand_sel_mux #(.WIDTH(16), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
        .xfer_cnt(xfer_cnt3)
`ifdef OPERAND_SEL_RANGE_CHK_EN
        , .sel_err(sel_err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // A transfer will happen on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL scoreboard: unexpected output data=%h sel=%0d with empty queue", out_data, out_sel);
            end else begin
                e = exp_q.pop_front();
                if (out_data === e.data && out_sel === e.sel) begin
                    pass_cnt++;
                end else begin
                    $display("[TB] FAIL scoreboard: got data=%h sel=%0d expected data=%h sel=%0d",
                             out_data, out_sel, e.data, e.sel);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one word and hold it until accepted; the expected word is queued once acceptance is certain.
    task automatic applyStimulus(input logic [1:0] s, input logic [15:0] exp_d);
        bit done;
        exp_t e;
        done = 1'b0;
        @(posedge clk);
        #1;
        sel      = s;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = exp_d;
                e.sel  = s;
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                stall_cycles++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            check_cnt++;
            $display("[TB] FAIL accept_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic idleInput();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainOutput();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drain", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        check_cnt    = 0;
        pass_cnt     = 0;
        stall_cycles = 0;
        in_bus       = '0;
        sel          = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        in_bus3      = {16'h3333, 16'h2222, 16'h1111};
        sel3         = '0;
        in_valid3    = 1'b0;
        out_ready3   = 1'b1;
        stream_exp   = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

        // Reset state
        resetDut();
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
        checkOutput("rst_out_sel", {30'd0, out_sel}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

        // Single transfer, sel=2
        in_bus = {16'h0011, 16'h0010, 16'h0001, 16'h0000};
        applyStimulus(2'd2, 16'h0010);
        idleInput();
        checkOutput("single_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("single_out_data", {16'd0, out_data}, 32'h0010);
        drainOutput();
        checkOutput("single_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);

        // Streaming 8 back-to-back words
        resetDut();
        in_bus       = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'(i % 4), stream_exp[i % 4]);
        end
        idleInput();
        drainOutput();
        checkOutput("stream_stalls", stall_cycles, 32'd0);
        checkOutput("stream_xfer_cnt", {16'd0, xfer_cnt}, 32'd8);

        // Back-pressure: A held, B to skid, C waits
        resetDut();
        out_ready = 1'b0;
        applyStimulus(2'd1, 16'hBBBB);
        applyStimulus(2'd3, 16'hDDDD);
        fork
            applyStimulus(2'd2, 16'hCCCC);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checkOutput("bp_hold_data", {16'd0, out_data}, 32'hBBBB);
                    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idleInput();
        drainOutput();
        checkOutput("bp_xfer_cnt", {16'd0, xfer_cnt}, 32'd3);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        applyStimulus(2'd0, 16'hAAAA);
        applyStimulus(2'd1, 16'hBBBB);
        idleInput();
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_out_data", {16'd0, out_data}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("postrst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

        // Out-of-range select on the 3-input instance
        @(posedge clk);
        #1;
        sel3      = 2'd3;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        checkOutput("range_out_valid", {31'd0, out_valid3}, 32'd1);
        checkOutput("range_out_data", {16'd0, out_data3}, 32'd0);
`ifdef OPERAND_SEL_RANGE_CHK_EN
        checkOutput("range_sel_err", {31'd0, sel_err3}, 32'd1);
        checkOutput("pow2_sel_err", {31'd0, sel_err}, 32'd0);
`endif
        sel3      = 2'd1;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        checkOutput("range_valid_data", {16'd0, out_data3}, 32'h2222);
        checkOutput("range_valid_sel", {30'd0, out_sel3}, 32'd1);
`ifdef OPERAND_SEL_RANGE_CHK_EN
        checkOutput("range_sel_err_sticky", {31'd0, sel_err3}, 32'd1);
`endif

        // xfer_cnt wrap after 65536 transfers
        resetDut();
`ifdef OPERAND_SEL_RANGE_CHK_EN
        checkOutput("range_sel_err_reset", {31'd0, sel_err3}, 32'd0);
`endif
        in_bus = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(2'(i % 4), stream_exp[i % 4]);
        end
        idleInput();
        drainOutput();
        checkOutput("wrap_cnt_max", {16'd0, xfer_cnt}, 32'h0000FFFF);
        applyStimulus(2'd3, 16'hDDDD);
        idleInput();
        drainOutput();
        checkOutput("wrap_cnt_zero", {16'd0, xfer_cnt}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/operand_sel_mux.md
Name: operand_sel_mux

Overview:
- Registered, parametrised N:1 operand-select multiplexer for the 16-bit CPU datapath.
- Successor to the fixed 2:1 clocked B-operand mux: the data width and input count are parameters, and it adds a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput under back-pressure.
- Sits between register-file/immediate sources and the ALU B-operand input.

Parameters:
- WIDTH, 16, data width of each input and the output.
- NUM_IN, 4, number of selectable inputs (>=2).
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  NUM_IN*WIDTH  flattened inputs; input k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select, sampled with in_valid.
- in_valid  input  1  upstream has a sel/in_bus pair.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected, registered operand.
- out_sel  output  SEL_W  select value that produced out_data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- xfer_cnt  output  16  count of completed output transfers.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0, xfer_cnt=0.
  - Skid entry empty, so in_ready=1 in the first cycle after reset deassertion.
- Accept occurs when in_valid && in_ready at a rising clk edge. The captured data is in_bus[sel] if sel<NUM_IN, else all-zero.
- Latency: 1 cycle. A word accepted at edge t appears on out_data with out_valid=1 after edge t.
- Output transfer occurs when out_valid && out_ready.
- Storage: main register (drives the outputs) plus one skid register.
- States, encoded by {skid_valid, out_valid}:
  - EMPTY (0,0):
    - accept -> LOAD into the main register -> HALF.
  - HALF (0,1):
    - accept with transfer -> the main register takes the new word; stay HALF.
    - accept without transfer -> the word goes to the skid register -> FULL.
    - transfer without accept -> EMPTY.
    - neither -> hold.
  - FULL (1,1):
    - in_ready=0.
    - transfer -> the skid word moves to the main register -> HALF.
    - otherwise hold.
- in_ready = ~skid_valid. It is registered, with no combinational path from out_ready.
- Ordering is strictly FIFO. Data is never dropped or duplicated.
- While out_valid=1 && out_ready=0, out_data and out_sel are stable.
- in_valid while in_ready=0 is ignored. Upstream holds its data until accepted.
- xfer_cnt increments by 1 on each output transfer and wraps 0xFFFF -> 0x0000.
- rst_n asserted mid-operation: all storage is cleared immediately (asynchronously) and buffered words are discarded.
- sel changing between accepts has no effect on words already stored.

Optional Feature:
- Macro: OPERAND_SEL_RANGE_CHK_EN.
- Defined:
  - Extra output port sel_err (1 bit, output).
  - sel_err is sticky: it sets on any accept with sel>=NUM_IN and clears only on reset.
  - The accepted word is still zeroed.
- Not defined:
  - No sel_err port.
  - Out-of-range sel silently yields zero data.
- When NUM_IN is a power of two, sel_err can never set.

Test Plan:
1. Reset, then idle -> out_valid=0, out_data=0, in_ready=1, xfer_cnt=0.
2. Single transfer:
   - Stimulus: NUM_IN=4, in_bus={16'h0011,16'h0010,16'h0001,16'h0000}, sel=2, in_valid for 1 cycle, out_ready=1.
   - Response: next cycle out_data=16'h0010, out_sel=2, out_valid=1; xfer_cnt=1 after the transfer.
3. Streaming:
   - Stimulus: 8 back-to-back accepts with sel=0,1,2,3,0,1,2,3 and out_ready held 1.
   - Response: one output per cycle in the same order; in_ready stays 1; xfer_cnt=8.
4. Back-pressure:
   - Stimulus: out_ready=0 while sending 3 words A, B, C.
   - Response:
     - A is held on out_data.
     - B goes to the skid register; in_ready=0 after B.
     - C is ignored until in_ready=1.
     - Releasing out_ready yields A, B, then C in order.
5. Reset mid-stream:
   - Stimulus: assert rst_n=0 asynchronously (between edges) while in state FULL.
   - Response: out_valid=0 and in_ready=1 immediately; no stale words appear after release.
6. Range check (NUM_IN=3, OPERAND_SEL_RANGE_CHK_EN defined):
   - Stimulus: sel=3 accepted.
   - Response: out_data=0; sel_err=1 and it stays 1 through later valid selects until reset.
   - Also verify xfer_cnt wraps 0xFFFF -> 0 by forcing 65536 transfers.
